// File: rtl/pipe_array_mult.sv
`default_nettype none
// ==========================================================================
// pipe_array_mult : pipelined array multiplier, unsigned or two's-complement
// per operation, valid/ready handshake with stall and bubble collapse.
// Revision: 1.0
// ==========================================================================
module pipe_array_mult #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic                         tc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2*WIDTH-1:0]           result,
  output logic [$clog2(STAGES+1)-1:0]  inflight
);
  localparam int PW   = 2 * WIDTH;
  localparam int CW   = $clog2(STAGES + 1);
  localparam int ROWS = (WIDTH + STAGES - 1) / STAGES;

  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  a_q     [STAGES];
  logic [WIDTH-1:0]  b_q     [STAGES];
  logic              tc_q    [STAGES];
  logic [PW-1:0]     sum_q   [STAGES];

  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] up_v;
  logic [WIDTH-1:0]  up_a    [STAGES];
  logic [WIDTH-1:0]  up_b    [STAGES];
  logic              up_tc   [STAGES];
  logic [PW-1:0]     up_sum  [STAGES];
  logic [PW-1:0]     nxt_sum [STAGES];
  logic              accept;
  logic              consume;

  function automatic logic [PW-1:0] add_rows(
    input logic [PW-1:0]    s_in,
    input logic [WIDTH-1:0] op_a,
    input logic [WIDTH-1:0] op_b,
    input logic             op_tc,
    input int               lo,
    input int               hi
  );
    logic [PW-1:0] a_ext;
    logic [PW-1:0] s;
    a_ext = op_tc ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
    s     = s_in;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= lo && i < hi && op_b[i]) begin
        // In two's complement the multiplier MSB row has weight -2^(WIDTH-1).
        if (op_tc && i == WIDTH - 1) s = s - (a_ext << i);
        else                         s = s + (a_ext << i);
      end
    end
    return s;
  endfunction

  always_comb begin
    up_v[0]   = in_valid;
    up_a[0]   = a;
    up_b[0]   = b;
    up_tc[0]  = tc;
    up_sum[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      up_v[k]   = vld[k-1];
      up_a[k]   = a_q[k-1];
      up_b[k]   = b_q[k-1];
      up_tc[k]  = tc_q[k-1];
      up_sum[k] = sum_q[k-1];
    end
    // A stage can load if any stage at or after it has a hole, or the sink drains.
    for (int k = 0; k < STAGES; k++) begin
      rdy[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!vld[j]) rdy[k] = 1'b1;
      end
      nxt_sum[k] = add_rows(up_sum[k], up_a[k], up_b[k], up_tc[k], k * ROWS,
                            ((k + 1) * ROWS > WIDTH) ? WIDTH : (k + 1) * ROWS);
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[STAGES-1];
  assign result    = sum_q[STAGES-1];
  assign accept    = in_valid && rdy[0];
  assign consume   = vld[STAGES-1] && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld      <= '0;
      inflight <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        tc_q[k]  <= 1'b0;
        sum_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          // Bubbles load zeros so an idle pipe presents a zero result.
          vld[k]   <= up_v[k];
          a_q[k]   <= up_v[k] ? up_a[k]    : '0;
          b_q[k]   <= up_v[k] ? up_b[k]    : '0;
          tc_q[k]  <= up_v[k] ? up_tc[k]   : 1'b0;
          sum_q[k] <= up_v[k] ? nxt_sum[k] : '0;
        end
      end
      if (accept && !consume)      inflight <= inflight + CW'(1);
      else if (!accept && consume) inflight <= inflight - CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_array_mult.sv
`default_nettype none
// tb_pipe_array_mult : directed and randomized checks of pipe_array_mult
// against a plain-arithmetic product model.
module tb_pipe_array_mult;
  localparam int NCFG = 12;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, tc, out_ready;
  logic [5:0]  a, b;
  logic        in_ready, out_valid;
  logic [11:0] result;
  logic [1:0]  inflight;

  int errors = 0;
  int checks = 0;

  logic        s_ir, s_ov;
  logic [11:0] s_res;
  logic [1:0]  s_inf;

  pipe_array_mult #(.WIDTH(6), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .tc(tc), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .inflight(inflight)
  );

  function automatic int cfg_w(input int i);
    case (i / 3)
      0:       return 4;
      1:       return 6;
      2:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_s(input int i);
    case (i % 3)
      0:       return 1;
      1:       return 2;
      default: return cfg_w(i);
    endcase
  endfunction

  logic [15:0] sw_a    [NCFG];
  logic [15:0] sw_b    [NCFG];
  logic        sw_v    [NCFG];
  logic        sw_tc   [NCFG];
  logic        sw_ordy [NCFG];
  logic        sw_ir   [NCFG];
  logic        sw_ov   [NCFG];
  logic [31:0] sw_res  [NCFG];
  logic [4:0]  sw_inf  [NCFG];

  genvar gi;
  generate
    for (gi = 0; gi < NCFG; gi++) begin : g_sweep
      localparam int W = cfg_w(gi);
      localparam int S = cfg_s(gi);
      logic [2*W-1:0]         res;
      logic [$clog2(S+1)-1:0] inf;
      logic                   ir, ov;
      pipe_array_mult #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk(clk), .rst(rst), .in_valid(sw_v[gi]), .in_ready(ir),
        .a(sw_a[gi][W-1:0]), .b(sw_b[gi][W-1:0]), .tc(sw_tc[gi]),
        .out_valid(ov), .out_ready(sw_ordy[gi]), .result(res), .inflight(inf)
      );
      assign sw_ir[gi]  = ir;
      assign sw_ov[gi]  = ov;
      assign sw_res[gi] = 32'(res);
      assign sw_inf[gi] = 5'(inf);
    end
  endgenerate

  // Exact product of w-bit operands, reduced to 2w bits.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input logic t);
    longint xv, yv, p;
    xv = longint'(x);
    yv = longint'(y);
    if (t && x[w-1]) xv = xv - (longint'(1) << w);
    if (t && y[w-1]) yv = yv - (longint'(1) << w);
    p = xv * yv;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic step(input logic r, input logic v, input logic [5:0] xa,
                      input logic [5:0] xb, input logic t, input logic ordy);
    @(negedge clk);
    rst = r; in_valid = v; a = xa; b = xb; tc = t; out_ready = ordy;
    #1;
    s_ir = in_ready; s_ov = out_valid; s_res = result; s_inf = inflight;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 6'h15, 6'h2A, 1'b0, 1'b0);
    step(1'b1, 1'b1, 6'h15, 6'h2A, 1'b0, 1'b0);
    step(1'b0, 1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
    checks++; if (s_ir !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", s_ir); end
    checks++; if (s_ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", s_ov); end
    checks++; if (s_res !== 12'h000) begin errors++; $display("FAIL reset_result: got %h want 000", s_res); end
    checks++; if (s_inf !== 2'd0) begin errors++; $display("FAIL reset_inflight: got %0d want 0", s_inf); end
  endtask

  task automatic test_basic();
    step(1'b0, 1'b1, 6'd63, 6'd63, 1'b0, 1'b1);
    checks++; if (s_ir !== 1'b1) begin errors++; $display("FAIL basic_accept: in_ready %b want 1", s_ir); end
    step(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
    checks++; if (s_ov !== 1'b0) begin errors++; $display("FAIL basic_early: out_valid %b want 0 at cycle 1", s_ov); end
    step(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
    checks++; if (s_ov !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid %b want 1 at cycle 2", s_ov); end
    checks++; if (s_res !== 12'hF81) begin errors++; $display("FAIL basic_result: got %h want f81", s_res); end
    idle(3);
  endtask

  task automatic run_pair_list(input string name, input int n, input logic [5:0] xa[3],
                               input logic [5:0] xb[3], input logic t[3], input logic [11:0] ex[3]);
    for (int i = 0; i < n + 3; i++) begin
      if (i < n) step(1'b0, 1'b1, xa[i], xb[i], t[i], 1'b1);
      else       step(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
      if (i < n) begin
        checks++; if (s_ir !== 1'b1) begin errors++; $display("FAIL %s_ready[%0d]: got %b want 1", name, i, s_ir); end
      end
      if (i >= 2 && i < n + 2) begin
        checks++; if (s_ov !== 1'b1) begin errors++; $display("FAIL %s_valid[%0d]: got %b want 1", name, i - 2, s_ov); end
        checks++; if (s_res !== ex[i-2]) begin errors++; $display("FAIL %s_result[%0d]: got %h want %h", name, i - 2, s_res, ex[i-2]); end
      end
      if (i == n + 2) begin
        checks++; if (s_ov !== 1'b0) begin errors++; $display("FAIL %s_drained: out_valid %b want 0", name, s_ov); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  xa[3], xb[3];
    logic        t[3];
    logic [11:0] ex[3];
    xa = '{6'h20, 6'h3F, 6'h1F};
    xb = '{6'h20, 6'h05, 6'h20};
    t  = '{1'b1, 1'b1, 1'b1};
    ex = '{12'h400, 12'hFFB, 12'hC20};
    run_pair_list("b2b", 3, xa, xb, t, ex);
    idle(2);
  endtask

  task automatic test_mixed_modes();
    logic [5:0]  xa[3], xb[3];
    logic        t[3];
    logic [11:0] ex[3];
    xa = '{6'h3F, 6'h3F, 6'h00};
    xb = '{6'h02, 6'h02, 6'h00};
    t  = '{1'b0, 1'b1, 1'b0};
    ex = '{12'h07E, 12'hFFE, 12'h000};
    run_pair_list("mixed", 2, xa, xb, t, ex);
    idle(2);
  endtask

  task automatic test_backpressure();
    logic [5:0]  xa[4], xb[4];
    logic        t[4];
    logic [11:0] ex[4];
    int          idx, got;
    logic        v;
    for (int i = 0; i < 4; i++) begin
      xa[i] = 6'($urandom); xb[i] = 6'($urandom); t[i] = 1'($urandom);
      ex[i] = 12'(ref_mul(6, 16'(xa[i]), 16'(xb[i]), t[i]));
    end
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b1, xa[idx], xb[idx], t[idx], 1'b0);
      if (s_ir && idx < 3) idx++;
    end
    checks++; if (idx !== 2) begin errors++; $display("FAIL bp_accepts: got %0d want 2", idx); end
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 1'b1, xa[idx], xb[idx], t[idx], 1'b0);
      checks++; if (s_ir !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", s_ir); end
      checks++; if (s_inf !== 2'd2) begin errors++; $display("FAIL bp_inflight: got %0d want 2", s_inf); end
      checks++; if (s_ov !== 1'b1 || s_res !== ex[0]) begin
        errors++; $display("FAIL bp_held: valid %b result %h want 1 %h", s_ov, s_res, ex[0]);
      end
    end
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      v = (idx < 4);
      step(1'b0, v, xa[v ? idx : 0], xb[v ? idx : 0], t[v ? idx : 0], 1'b1);
      if (s_ov) begin
        checks++; if (s_res !== ex[got]) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", got, s_res, ex[got]); end
        got++;
      end
      if (v && s_ir) idx++;
    end
    checks++; if (got !== 4 || idx !== 4) begin errors++; $display("FAIL bp_delivered: got %0d accepted %0d want 4 4", got, idx); end
    step(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
    checks++; if (s_ov !== 1'b0 || s_inf !== 2'd0) begin
      errors++; $display("FAIL bp_extra: valid %b inflight %0d want 0 0", s_ov, s_inf);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    step(1'b0, 1'b1, 6'($urandom), 6'($urandom), 1'b0, 1'b0);
    step(1'b0, 1'b1, 6'($urandom), 6'($urandom), 1'b1, 1'b0);
    step(1'b1, 1'b1, 6'h11, 6'h22, 1'b0, 1'b1);
    checks++; if (s_inf !== 2'd2) begin errors++; $display("FAIL rmid_pre: inflight %0d want 2", s_inf); end
    step(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
    checks++; if (s_ov !== 1'b0 || s_inf !== 2'd0 || s_res !== 12'h000 || s_ir !== 1'b1) begin
      errors++; $display("FAIL rmid_post: valid %b inflight %0d result %h ready %b want 0 0 000 1", s_ov, s_inf, s_res, s_ir);
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
      if (s_ov) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_ghost: %0d stale outputs want 0", seen); end
  endtask

  task automatic test_sweep(input int idx);
    int          w, s, c;
    logic [15:0] m, xa, xb;
    logic        t, v, ordy, ir, ov, unst;
    logic [31:0] res, e;
    logic [4:0]  inf;
    logic [31:0] expq[$];
    int          accq[$];
    w = cfg_w(idx);
    s = cfg_s(idx);
    m = 16'((32'd1 << w) - 1);
    step(1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1);
    for (c = 0; c < 140; c++) begin
      unst = (c < 30);
      v    = unst ? 1'b1 : ($urandom_range(0, 3) != 0);
      ordy = unst ? 1'b1 : 1'($urandom_range(0, 1));
      if (c >= 110) begin v = 1'b0; ordy = 1'b1; end
      xa = 16'($urandom) & m;
      xb = 16'($urandom) & m;
      t  = 1'($urandom_range(0, 1));
      @(negedge clk);
      rst = 1'b0;
      sw_v[idx] = v; sw_a[idx] = xa; sw_b[idx] = xb; sw_tc[idx] = t; sw_ordy[idx] = ordy;
      #1;
      ir = sw_ir[idx]; ov = sw_ov[idx]; res = sw_res[idx]; inf = sw_inf[idx];
      checks++; if (int'(inf) !== expq.size()) begin
        errors++; $display("FAIL sweep%0d_inflight c%0d: got %0d want %0d", idx, c, inf, expq.size());
      end
      if (unst || (int'(inf) == s && !ordy)) begin
        checks++; if (ir !== unst) begin errors++; $display("FAIL sweep%0d_ready c%0d: got %b want %b", idx, c, ir, unst); end
      end
      if (ov && ordy) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL sweep%0d_spurious c%0d: result %h with nothing pending", idx, c, res);
        end else begin
          e = expq.pop_front();
          if (res !== e) begin errors++; $display("FAIL sweep%0d_result c%0d: got %h want %h", idx, c, res, e); end
          if (c < 30) begin
            checks++; if (c - accq[0] !== s) begin errors++; $display("FAIL sweep%0d_latency: got %0d want %0d", idx, c - accq[0], s); end
          end
          void'(accq.pop_front());
        end
      end
      if (v && ir) begin
        expq.push_back(ref_mul(w, xa, xb, t));
        accq.push_back(c);
      end
      @(posedge clk);
    end
    @(negedge clk);
    sw_v[idx] = 1'b0;
    checks++; if (expq.size() != 0) begin errors++; $display("FAIL sweep%0d_lost: %0d products never delivered", idx, expq.size()); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; tc = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < NCFG; i++) begin
      sw_a[i] = '0; sw_b[i] = '0; sw_v[i] = 1'b0; sw_tc[i] = 1'b0; sw_ordy[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_mixed_modes();
    test_backpressure();
    test_reset_mid();
    for (int i = 0; i < NCFG; i++) test_sweep(i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
